apb_master: RTL and testbench

- APB4 initiator (requester) that drives the APB responder blocks in the AMBA library from a simple valid/ready command channel.
- Accepts one request, runs the APB SETUP/ACCESS phases, honours wait states, and returns read data plus error status on a valid/ready response channel.
- An optional wait-state timeout aborts a transfer whose responder hangs.
- Sits between a local controller or bridge and an APB peripheral bus.

---
 rtl/apb_master_if.sv | 51 +++++
 rtl/apb_master.sv | 103 ++++++++++
 tb/tb_apb_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - request/response channel and APB bus bundle for apb_master
// Purpose: groups the command channel, response channel and APB signals.
// Ports (modports):
//   master - view of apb_master: drives req_ready, rsp_*, psel/penable/pprot/pwrite/paddr/pstrb/pwdata
//   slave  - view of the controller and APB responder: the complementary directions
interface apb_master_if #(
    parameter int AWIDTH = 10,
    parameter int DSIZE  = 2
);
    localparam int DBYTES = 1 << DSIZE;
    localparam int DWIDTH = DBYTES * 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic [DBYTES-1:0] req_strb;
    logic [2:0]        req_prot;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic [2:0]        pprot;
    logic              pwrite;
    logic [AWIDTH-1:0] paddr;
    logic [DBYTES-1:0] pstrb;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  rsp_ready, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pprot, pwrite, paddr, pstrb, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output rsp_ready, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pprot, pwrite, paddr, pstrb, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB4 requester driven by a valid/ready command channel
// Purpose: accepts one request, runs APB SETUP/ACCESS with wait states and an
// optional wait-state timeout, and returns read data and error status.
// Ports:
//   pclk    - clock
//   aresetn - asynchronous active-low reset
//   bus     - apb_master_if.master: req_* command channel, rsp_* response channel, APB bus
module apb_master #(
    parameter int AWIDTH  = 10,
    parameter int DSIZE   = 2,
    parameter int DBYTES  = 1 << DSIZE,
    parameter int DWIDTH  = DBYTES * 8,
    parameter int TIMEOUT = 16
) (
    input  logic         pclk,
    input  logic         aresetn,
    apb_master_if.master bus
);
    localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen on the last permitted wait cycle; reaching it with
    // pready still low aborts the transfer.
    localparam logic [CW-1:0] LAST_WAIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          accept;

    // In RESP the response handshake frees the slot, so a new request can be
    // taken in the same cycle.
    assign bus.req_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pprot       <= 3'b000;
            bus.pwrite      <= 1'b0;
            bus.paddr       <= '0;
            bus.pstrb       <= '0;
            bus.pwdata      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                SETUP: begin
                    bus.penable <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= bus.pwrite ? DWIDTH'(0) : bus.prdata;
                        bus.rsp_err     <= bus.pslverr;
                        bus.rsp_timeout <= 1'b0;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if ((TIMEOUT != 0) && (wait_cnt == LAST_WAIT)) begin
                            bus.psel        <= 1'b0;
                            bus.penable     <= 1'b0;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_rdata   <= DWIDTH'(0);
                            bus.rsp_err     <= 1'b1;
                            bus.rsp_timeout <= 1'b1;
                            state           <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Accept overrides the IDLE/RESP next-state choice above, giving
            // back-to-back RESP -> SETUP when a request is waiting.
            if (accept) begin
                bus.paddr   <= bus.req_addr[AWIDTH-1:0];
                bus.pwrite  <= bus.req_write;
                bus.pprot   <= bus.req_prot;
                bus.pwdata  <= bus.req_wdata;
                bus.pstrb   <= bus.req_write ? bus.req_strb : DBYTES'(0);
                bus.psel    <= 1'b1;
                bus.penable <= 1'b0;
                state       <= SETUP;
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;
    logic pclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    apb_master_if #(.AWIDTH(10), .DSIZE(2)) bus();
    apb_master_if #(.AWIDTH(10), .DSIZE(2)) bus0();

    apb_master #(.AWIDTH(10), .DSIZE(2), .TIMEOUT(4)) dut (
        .pclk(pclk), .aresetn(aresetn), .bus(bus));
    apb_master #(.AWIDTH(10), .DSIZE(2), .TIMEOUT(0)) dut0 (
        .pclk(pclk), .aresetn(aresetn), .bus(bus0));

    // Memory-backed responder with programmable wait states, error and hang.
    logic [31:0] mem [0:255];
    int   wcnt = 0;
    int   stub_waits = 0;
    logic stub_hang = 1'b0;
    logic stub_err = 1'b0;

    assign bus.pready  = !stub_hang && (wcnt >= stub_waits);
    assign bus.prdata  = mem[bus.paddr[9:2]];
    assign bus.pslverr = stub_err;

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && !bus.pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite)
            for (int b = 0; b < 4; b++)
                if (bus.pstrb[b]) mem[bus.paddr[9:2]][8*b +: 8] <= bus.pwdata[8*b +: 8];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request at a negedge and waits (bounded) for rsp_valid.
    task automatic xfer(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er,
                        output logic to, output int acc, output int lat,
                        output logic setup_ok, output logic stable, output logic [3:0] ps);
        logic [9:0]  sa;
        logic        sw;
        logic [3:0]  sst;
        logic [31:0] swd;
        @(negedge pclk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_strb  = st;
        bus.req_prot  = 3'b010;
        @(negedge pclk);
        bus.req_valid = 1'b0;
        setup_ok = bus.psel && !bus.penable;
        sa = bus.paddr; sw = bus.pwrite; sst = bus.pstrb; swd = bus.pwdata; ps = bus.pstrb;
        acc = 0; lat = 1; stable = 1'b1;
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge pclk);
            lat++;
            if (bus.psel && bus.penable) begin
                acc++;
                if (bus.paddr !== sa || bus.pwrite !== sw || bus.pstrb !== sst || bus.pwdata !== swd)
                    stable = 1'b0;
            end
        end
        if (!bus.rsp_valid) begin lat = 9999; acc = 9999; end
        rd = bus.rsp_rdata; er = bus.rsp_err; to = bus.rsp_timeout;
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.req_strb = 0; bus.req_prot = 0; bus.rsp_ready = 1;
        bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
        bus0.req_strb = 0; bus0.req_prot = 0; bus0.rsp_ready = 1;
        bus0.pready = 0; bus0.prdata = 0; bus0.pslverr = 0;
        aresetn = 1'b0;
        repeat (2) @(negedge pclk);
        tests++;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.pwrite} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 000000",
                {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.pwrite});
        end
        tests++;
        if (bus.paddr !== 10'h0 || bus.pstrb !== 4'h0 || bus.pwdata !== 32'h0 || bus.rsp_rdata !== 32'h0 || bus.pprot !== 3'h0) begin
            fails++; $display("FAIL reset_data: got paddr=%h pstrb=%h pwdata=%h rdata=%h pprot=%h expected all 0",
                bus.paddr, bus.pstrb, bus.pwdata, bus.rsp_rdata, bus.pprot);
        end
        aresetn = 1'b1;
        @(negedge pclk);
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er, to, su, stb; int acc, lat; logic [3:0] ps;
        xfer(1'b1, 10'h004, 32'hDEADBEEF, 4'hF, rd, er, to, acc, lat, su, stb, ps);
        tests++;
        if (su !== 1'b1 || acc !== 1 || lat !== 3) begin
            fails++; $display("FAIL zw_write_phases: got setup=%b access=%0d latency=%0d expected 1 1 3", su, acc, lat);
        end
        tests++;
        if (er !== 1'b0 || to !== 1'b0 || rd !== 32'h0 || bus.psel !== 1'b0) begin
            fails++; $display("FAIL zw_write_rsp: got err=%b to=%b rdata=%h psel=%b expected 0 0 0 0", er, to, rd, bus.psel);
        end
        tests++;
        if (bus.pprot !== 3'b010 || ps !== 4'hF) begin
            fails++; $display("FAIL zw_write_prot_strb: got pprot=%b pstrb=%h expected 010 f", bus.pprot, ps);
        end
        xfer(1'b0, 10'h004, 32'h0, 4'hF, rd, er, to, acc, lat, su, stb, ps);
        tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || ps !== 4'h0) begin
            fails++; $display("FAIL zw_read: got rdata=%h err=%b pstrb=%h expected deadbeef 0 0", rd, er, ps);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic er, to, su, stb; int acc, lat; logic [3:0] ps;
        xfer(1'b1, 10'h008, 32'h11223344, 4'hF, rd, er, to, acc, lat, su, stb, ps);
        xfer(1'b1, 10'h008, 32'hAABBCCDD, 4'h5, rd, er, to, acc, lat, su, stb, ps);
        xfer(1'b0, 10'h008, 32'h0, 4'h0, rd, er, to, acc, lat, su, stb, ps);
        tests++;
        if (rd !== 32'h11BB33DD) begin
            fails++; $display("FAIL strobes: got %h expected 11bb33dd", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er, to, su, stb; int acc, lat; logic [3:0] ps;
        xfer(1'b1, 10'h3FC, 32'hCAFEF00D, 4'hF, rd, er, to, acc, lat, su, stb, ps);
        stub_waits = 3;
        xfer(1'b0, 10'h3FC, 32'h0, 4'hF, rd, er, to, acc, lat, su, stb, ps);
        stub_waits = 0;
        tests++;
        if (acc !== 4 || stb !== 1'b1) begin
            fails++; $display("FAIL wait_access: got access=%0d stable=%b expected 4 1", acc, stb);
        end
        tests++;
        if (rd !== 32'hCAFEF00D || to !== 1'b0 || er !== 1'b0) begin
            fails++; $display("FAIL wait_rsp: got rdata=%h to=%b err=%b expected cafef00d 0 0", rd, to, er);
        end
    endtask

    task automatic test_slave_error();
        logic [31:0] rd; logic er, to, su, stb; int acc, lat; logic [3:0] ps;
        stub_err = 1'b1;
        xfer(1'b1, 10'h010, 32'h12345678, 4'hF, rd, er, to, acc, lat, su, stb, ps);
        stub_err = 1'b0;
        tests++;
        if (er !== 1'b1 || to !== 1'b0 || rd !== 32'h0) begin
            fails++; $display("FAIL slverr: got err=%b to=%b rdata=%h expected 1 0 0", er, to, rd);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er, to, su, stb; int acc, lat; logic [3:0] ps;
        stub_hang = 1'b1;
        xfer(1'b0, 10'h004, 32'h0, 4'h0, rd, er, to, acc, lat, su, stb, ps);
        stub_hang = 1'b0;
        tests++;
        if (acc !== 4 || bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
            fails++; $display("FAIL timeout_len: got access=%0d psel=%b penable=%b expected 4 0 0", acc, bus.psel, bus.penable);
        end
        tests++;
        if (er !== 1'b1 || to !== 1'b1 || rd !== 32'h0) begin
            fails++; $display("FAIL timeout_rsp: got err=%b to=%b rdata=%h expected 1 1 0", er, to, rd);
        end
        xfer(1'b0, 10'h004, 32'h0, 4'h0, rd, er, to, acc, lat, su, stb, ps);
        tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || to !== 1'b0 || acc !== 1) begin
            fails++; $display("FAIL after_timeout: got rdata=%h err=%b to=%b access=%0d expected deadbeef 0 0 1", rd, er, to, acc);
        end
    endtask

    task automatic test_no_timeout();
        logic ok;
        @(negedge pclk);
        bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 10'h020;
        @(negedge pclk);
        bus0.req_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (!(bus0.psel && bus0.penable && !bus0.rsp_valid)) ok = 1'b0;
        end
        tests++;
        if (ok !== 1'b1) begin
            fails++; $display("FAIL no_timeout_hold: got ok=%b expected 1", ok);
        end
        bus0.pready = 1'b1; bus0.prdata = 32'h12345678;
        @(negedge pclk);
        bus0.pready = 1'b0;
        tests++;
        if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== 32'h12345678 || bus0.rsp_err !== 1'b0 || bus0.rsp_timeout !== 1'b0) begin
            fails++; $display("FAIL no_timeout_done: got valid=%b rdata=%h err=%b to=%b expected 1 12345678 0 0",
                bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err, bus0.rsp_timeout);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er, to, su, stb, ok; int acc, lat; logic [3:0] ps;
        bus.rsp_ready = 1'b0;
        xfer(1'b0, 10'h008, 32'h0, 4'h0, rd, er, to, acc, lat, su, stb, ps);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 10'h00C;
        bus.req_wdata = 32'h55667788; bus.req_strb = 4'hF;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h11BB33DD || bus.req_ready !== 1'b0 || bus.psel !== 1'b0)
                ok = 1'b0;
        end
        tests++;
        if (ok !== 1'b1) begin
            fails++; $display("FAIL backpressure_hold: got ok=%b expected 1", ok);
        end
        bus.rsp_ready = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_req_ready: got %b expected 1", bus.req_ready);
        end
        @(negedge pclk);
        bus.req_valid = 1'b0;
        tests++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_setup: got psel=%b penable=%b rsp_valid=%b expected 1 0 0", bus.psel, bus.penable, bus.rsp_valid);
        end
        @(negedge pclk);
        tests++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b1) begin
            fails++; $display("FAIL b2b_access: got psel=%b penable=%b expected 1 1", bus.psel, bus.penable);
        end
        #1 aresetn = 1'b0;
        #1;
        tests++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_mid: got psel=%b penable=%b rsp_valid=%b expected 0 0 0", bus.psel, bus.penable, bus.rsp_valid);
        end
        @(negedge pclk);
        aresetn = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0 || bus.req_ready !== 1'b1) ok = 1'b0;
        end
        tests++;
        if (ok !== 1'b1) begin
            fails++; $display("FAIL reset_no_rsp: got ok=%b expected 1", ok);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_strobes();
        test_wait_states();
        test_slave_error();
        test_timeout();
        test_no_timeout();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
